life_fsm: RTL and testbench

LIFE_FSM -- requirements
Module: life_fsm

---
 rtl/life_fsm_if.sv | 22 ++
 rtl/life_fsm.sv | 58 +++++
 tb/tb_life_fsm.sv | 138 +++++++++++++
 3 files changed

// File: rtl/life_fsm_if.sv
// Handshake bundle for the milestone tracker: one step request in,
// current milestone code and status flags out.
interface life_fsm_if;
    logic       advance;
    logic [2:0] state_out;
    logic       done;
    logic       changed;

    modport master (
        output advance,
        input  state_out,
        input  done,
        input  changed
    );

    modport slave (
        input  advance,
        output state_out,
        output done,
        output changed
    );
endinterface

// File: rtl/life_fsm.sv
// Six-milestone linear progression FSM: one step per sampled advance,
// terminal at S_ONWARD, self-recovering from the two unused codes.
module life_fsm (
    input  logic         clk,
    input  logic         reset,
    life_fsm_if.slave    bus
);

    typedef enum logic [2:0] {
        S_UNDERGRAD = 3'd0,
        S_OIL_GAS   = 3'd1,
        S_MARINE    = 3'd2,
        S_MASTERS   = 3'd3,
        S_GRADUATED = 3'd4,
        S_ONWARD    = 3'd5
    } state_t;

    // Held as a raw 3-bit vector so the unused codes 6/7 stay representable.
    logic [2:0] state_q;
    logic [2:0] state_d;
    logic       changed_q;
    logic       changed_d;

    always_comb begin
        state_d   = state_q;
        changed_d = 1'b0;
        if (!reset) begin
            state_d = S_UNDERGRAD;
        end else begin
            case (state_q)
                S_UNDERGRAD: if (bus.advance) state_d = S_OIL_GAS;
                S_OIL_GAS:   if (bus.advance) state_d = S_MARINE;
                S_MARINE:    if (bus.advance) state_d = S_MASTERS;
                S_MASTERS:   if (bus.advance) state_d = S_GRADUATED;
                S_GRADUATED: if (bus.advance) state_d = S_ONWARD;
                S_ONWARD:    state_d = S_ONWARD;
                default:     state_d = S_UNDERGRAD;
            endcase
        end
        // Flag any edge on which the register will take a different value,
        // including reset or recovery pulling a non-zero code back to zero.
        changed_d = (state_d != state_q);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_UNDERGRAD;
        end else begin
            state_q <= state_d;
        end
        changed_q <= changed_d;
    end

    assign bus.state_out = state_q;
    assign bus.done      = (state_q == S_ONWARD);
    assign bus.changed   = changed_q;

endmodule

// File: tb/tb_life_fsm.sv
// Scoreboard bench for life_fsm: a reference model pushes expected outputs
// as each cycle is driven; they are popped and compared after the edge.
module tb_life_fsm;

    logic clk;
    logic reset;

    life_fsm_if bus ();

    life_fsm dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string tag;
        int    st;
        int    dn;
        int    ch;
        bit    ch_valid;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   m_state  = -1;   // unknown before the first reset edge

    task automatic check_val(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    function automatic int model_next(input int cur, input bit rst_n, input bit adv);
        if (!rst_n)                 return 0;
        if (cur < 0 || cur > 5)     return 0;
        if (adv && cur < 5)         return cur + 1;
        return cur;
    endfunction

    task automatic push_exp(input string tag, input int nxt);
        exp_t e;
        e.tag      = tag;
        e.st       = nxt;
        e.dn       = (nxt == 5) ? 1 : 0;
        e.ch       = (nxt != m_state) ? 1 : 0;
        e.ch_valid = (m_state >= 0);
        sb_q.push_back(e);
        m_state = nxt;
    endtask

    task automatic pop_cmp();
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val("scoreboard_empty", 0, 1);
            return;
        end
        e = sb_q.pop_front();
        check_val({e.tag, ".state"}, int'(bus.state_out), e.st);
        check_val({e.tag, ".done"},  int'(bus.done),      e.dn);
        if (e.ch_valid)
            check_val({e.tag, ".changed"}, int'(bus.changed), e.ch);
        $display("txn %-12s state=%0d done=%0d changed=%0d", e.tag,
                 bus.state_out, bus.done, bus.changed);
    endtask

    task automatic step(input string tag, input bit rst_n, input bit adv);
        @(negedge clk);
        reset       = rst_n;
        bus.advance = adv;
        push_exp(tag, model_next(m_state, rst_n, adv));
        @(posedge clk);
        #1;
        pop_cmp();
    endtask

    // Load an illegal code into the state register by overriding its next value for one edge.
    task automatic deposit(input string tag, input logic [2:0] code);
        @(negedge clk);
        reset       = 1'b1;
        bus.advance = 1'b0;
        force dut.state_d = code;
        push_exp(tag, int'(code));
        @(posedge clk);
        #1;
        release dut.state_d;
        pop_cmp();
    endtask

    initial begin
        reset       = 1'b0;
        bus.advance = 1'b0;

        step("rst0", 1'b0, 1'b0);
        step("rst1", 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step("idle", 1'b1, 1'b0);

        for (int i = 0; i < 5; i++) begin
            step("pulse", 1'b1, 1'b1);
            step("gap", 1'b1, 1'b0);
            step("gap", 1'b1, 1'b0);
        end

        for (int i = 0; i < 3; i++) step("term_adv", 1'b1, 1'b1);

        step("rst_from5", 1'b0, 1'b0);
        step("rel", 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) step("held", 1'b1, 1'b1);

        step("rst_again", 1'b0, 1'b0);
        step("rel", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step("to3", 1'b1, 1'b1);
        step("rst_adv", 1'b0, 1'b1);
        step("rel", 1'b1, 1'b0);
        step("post_rst", 1'b1, 1'b1);
        step("gap", 1'b1, 1'b0);

        deposit("force6", 3'd6);
        step("recover6", 1'b1, 1'b0);
        deposit("force7", 3'd7);
        step("recover7", 1'b1, 1'b1);
        deposit("force6r", 3'd6);
        step("rst_over6", 1'b0, 1'b1);
        step("rel", 1'b1, 1'b0);

        check_val("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
